dut_host_seq: RTL and testbench

- Upstream host sequencer that drives the `dut` register-mapped method interface (write/read ports, 3-bit address, 1-bit data).
- Accepts one operand pair (a, b) on a valid/ready stream and issues the `dut` method calls: write a, write b, poll y status, read y.
- Returns y, or a timeout error, on a valid/ready response stream.
- Sits between the testbench/system stimulus source and `dut`; replaces hand-sequenced bus accesses.

---
 rtl/dut_host_pkg.sv | 23 ++
 rtl/dut_host_seq.sv | 157 +++++++++++++++
 tb/tb_dut_host_seq.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dut_host_pkg.sv
// Shared types and default constants for the dut host sequencer.
package dut_host_pkg;

    // Sequencer state encoding; IDLE must stay at zero.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR_A = 3'd1,
        ST_WR_B = 3'd2,
        ST_POLL = 3'd3,
        ST_RD_Y = 3'd4,
        ST_RESP = 3'd5
    } state_e;

    // Default register map of the downstream dut.
    localparam logic [2:0] DEF_ADDR_A      = 3'd4;
    localparam logic [2:0] DEF_ADDR_B      = 3'd5;
    localparam logic [2:0] DEF_ADDR_Y_STAT = 3'd2;
    localparam logic [2:0] DEF_ADDR_Y_DATA = 3'd3;

    // Default number of y-status reads before giving up (legal 1..255).
    localparam int unsigned DEF_POLL_MAX = 16;

endpackage

// File: rtl/dut_host_seq.sv
// Host sequencer: takes an (a, b) pair, writes both into dut, polls the
// y status, reads y and returns it (or a poll timeout) on a response stream.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for an operand pair, in_ready high
// WR_A    | writing a_q to ADDR_A, stalls while write_rdy is low
// WR_B    | writing b_q to ADDR_B, stalls while write_rdy is low
// POLL    | reading ADDR_Y_STAT until it returns 1 or the poll budget ends
// RD_Y    | reading ADDR_Y_DATA to capture and dequeue y
// RESP    | presenting y / err until out_ready
module dut_host_seq
    import dut_host_pkg::*;
#(
    parameter logic [2:0]  ADDR_A      = DEF_ADDR_A,
    parameter logic [2:0]  ADDR_B      = DEF_ADDR_B,
    parameter logic [2:0]  ADDR_Y_STAT = DEF_ADDR_Y_STAT,
    parameter logic [2:0]  ADDR_Y_DATA = DEF_ADDR_Y_DATA,
    parameter int unsigned POLL_MAX    = DEF_POLL_MAX
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       in_valid,
    input  logic       in_a,
    input  logic       in_b,
    output logic       in_ready,
    output logic       out_valid,
    output logic       out_y,
    output logic       out_err,
    input  logic       out_ready,
    output logic [2:0] write_address,
    output logic       write_data,
    output logic       write_en,
    input  logic       write_rdy,
    output logic [2:0] read_address,
    output logic       read_en,
    input  logic       read_data,
    input  logic       read_rdy,
    output logic       busy
);

    // Count value at which a further empty status read ends the poll.
    localparam logic [7:0] POLL_LAST = 8'(POLL_MAX - 1);

    state_e     state_q, state_d;
    logic [7:0] poll_cnt_q, poll_cnt_d;
    logic       a_q, a_d;
    logic       b_q, b_d;
    logic       y_q, y_d;
    logic       err_q, err_d;

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            poll_cnt_q <= 8'd0;
            a_q        <= 1'b0;
            b_q        <= 1'b0;
            y_q        <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            poll_cnt_q <= poll_cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            y_q        <= y_d;
            err_q      <= err_d;
        end
    end

    // Next-state, datapath updates and method-call decode.
    always_comb begin
        state_d       = state_q;
        poll_cnt_d    = poll_cnt_q;
        a_d           = a_q;
        b_d           = b_q;
        y_d           = y_q;
        err_d         = err_q;
        in_ready      = 1'b0;
        out_valid     = 1'b0;
        out_y         = 1'b0;
        out_err       = 1'b0;
        write_address = 3'd0;
        write_data    = 1'b0;
        write_en      = 1'b0;
        read_address  = 3'd0;
        read_en       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d        = in_a;
                    b_d        = in_b;
                    poll_cnt_d = 8'd0;
                    state_d    = ST_WR_A;
                end
            end
            ST_WR_A: begin
                write_address = ADDR_A;
                write_data    = a_q;
                write_en      = write_rdy;
                if (write_rdy) begin
                    state_d = ST_WR_B;
                end
            end
            ST_WR_B: begin
                write_address = ADDR_B;
                write_data    = b_q;
                write_en      = write_rdy;
                if (write_rdy) begin
                    state_d = ST_POLL;
                end
            end
            ST_POLL: begin
                read_address = ADDR_Y_STAT;
                read_en      = read_rdy;
                if (read_rdy) begin
                    if (read_data) begin
                        state_d = ST_RD_Y;
                    end else begin
                        poll_cnt_d = poll_cnt_q + 8'd1;
                        if (poll_cnt_q == POLL_LAST) begin
                            // Timeout responses always carry y=0.
                            err_d   = 1'b1;
                            y_d     = 1'b0;
                            state_d = ST_RESP;
                        end
                    end
                end
            end
            ST_RD_Y: begin
                read_address = ADDR_Y_DATA;
                read_en      = read_rdy;
                if (read_rdy) begin
                    y_d     = read_data;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                out_valid = 1'b1;
                out_y     = y_q;
                out_err   = err_q;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dut_host_seq.sv
// Directed bench for dut_host_seq with a small behavioural dut model.
module tb_dut_host_seq;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_a = 1'b0;
    logic       in_b = 1'b0;
    logic       in_ready;
    logic       out_valid;
    logic       out_y;
    logic       out_err;
    logic       out_ready = 1'b1;
    logic [2:0] write_address;
    logic       write_data;
    logic       write_en;
    logic       write_rdy = 1'b1;
    logic [2:0] read_address;
    logic       read_en;
    logic       read_data;
    logic       read_rdy = 1'b1;
    logic       busy;

    int tests_run = 0;
    int tests_failed = 0;

    // Model knobs driven by the tests.
    logic stub_stat0 = 1'b0;

    // dut model state: one-entry a register and one-entry y register (y = a | b).
    logic       m_a_full = 1'b0;
    logic       m_a_val = 1'b0;
    logic       m_y_full = 1'b0;
    logic       m_y_val = 1'b0;
    int         cnt_wr5 = 0;
    int         cnt_rd2 = 0;
    int         cnt_rd3 = 0;
    logic [3:0] wr_h0 = 4'd0;
    logic [3:0] wr_h1 = 4'd0;
    int         excl_viol = 0;

    always #5 CLK = ~CLK;

    dut_host_seq #(.POLL_MAX(4)) u_dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .in_valid      (in_valid),
        .in_a          (in_a),
        .in_b          (in_b),
        .in_ready      (in_ready),
        .out_valid     (out_valid),
        .out_y         (out_y),
        .out_err       (out_err),
        .out_ready     (out_ready),
        .write_address (write_address),
        .write_data    (write_data),
        .write_en      (write_en),
        .write_rdy     (write_rdy),
        .read_address  (read_address),
        .read_en       (read_en),
        .read_data     (read_data),
        .read_rdy      (read_rdy),
        .busy          (busy)
    );

    assign read_data = (read_address == 3'd2) ? (m_y_full & ~stub_stat0) :
                       (read_address == 3'd3) ? m_y_val : 1'b0;

    // Behavioural dut: accepts writes/reads and keeps access tallies.
    always @(posedge CLK) begin
        if (write_en && write_rdy) begin
            wr_h1 <= wr_h0;
            wr_h0 <= {write_address, write_data};
            if (write_address == 3'd4) begin
                m_a_full <= 1'b1;
                m_a_val  <= write_data;
            end
            if (write_address == 3'd5) begin
                cnt_wr5 <= cnt_wr5 + 1;
                if (m_a_full) begin
                    m_a_full <= 1'b0;
                    m_y_full <= 1'b1;
                    m_y_val  <= m_a_val | write_data;
                end
            end
        end
        if (read_en && read_rdy) begin
            if (read_address == 3'd2) cnt_rd2 <= cnt_rd2 + 1;
            if (read_address == 3'd3) begin
                cnt_rd3  <= cnt_rd3 + 1;
                m_y_full <= 1'b0;
            end
        end
    end

    // Tally bus-protocol violations: both enables, or an enable while idle/responding.
    always @(negedge CLK) begin
        if (RST_N && ((write_en && read_en) || ((write_en || read_en) && (!busy || out_valid))))
            excl_viol <= excl_viol + 1;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_resp(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (out_valid) ok = 1'b1;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        tick();
        tick();
        RST_N = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        tests_run++;
        if ({write_en, read_en} !== 2'b00) begin tests_failed++; $display("FAIL reset_en got=%b exp=00", {write_en, read_en}); end
        tests_run++;
        if ({write_address, read_address, write_data} !== 7'd0) begin tests_failed++; $display("FAIL reset_addr_data got=%b exp=0", {write_address, read_address, write_data}); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got=%b exp=0", busy); end
    endtask

    task automatic test_basic();
        int rd2_0, rd3_0;
        rd2_0 = cnt_rd2;
        rd3_0 = cnt_rd3;
        out_ready = 1'b1;
        in_a = 1'b1; in_b = 1'b0; in_valid = 1'b1;
        tick();                       // edge 0: accept
        in_valid = 1'b0;
        tests_run++;
        if ({in_ready, write_en, write_address, write_data} !== {1'b0, 1'b1, 3'd4, 1'b1})
            begin tests_failed++; $display("FAIL basic_wr_a got rdy/en/addr/data=%b exp=0_1_100_1", {in_ready, write_en, write_address, write_data}); end
        tick();                       // edge 1
        tests_run++;
        if ({write_en, write_address, write_data} !== {1'b1, 3'd5, 1'b0})
            begin tests_failed++; $display("FAIL basic_wr_b got en/addr/data=%b exp=1_101_0", {write_en, write_address, write_data}); end
        tick();                       // edge 2
        tests_run++;
        if ({wr_h1, wr_h0} !== {3'd4, 1'b1, 3'd5, 1'b0})
            begin tests_failed++; $display("FAIL basic_write_hist got=%b exp=1001_1010", {wr_h1, wr_h0}); end
        tests_run++;
        if ({read_en, read_address, read_data} !== {1'b1, 3'd2, 1'b1})
            begin tests_failed++; $display("FAIL basic_poll got en/addr/data=%b exp=1_010_1", {read_en, read_address, read_data}); end
        tick();                       // edge 3
        tests_run++;
        if ({read_en, read_address} !== {1'b1, 3'd3})
            begin tests_failed++; $display("FAIL basic_rd_y got en/addr=%b exp=1_011", {read_en, read_address}); end
        tick();                       // edge 4
        tests_run++;
        if ({out_valid, out_y, out_err} !== 3'b110)
            begin tests_failed++; $display("FAIL basic_resp_edge4 got v/y/err=%b exp=110", {out_valid, out_y, out_err}); end
        tests_run++;
        if ((cnt_rd2 - rd2_0) !== 1 || (cnt_rd3 - rd3_0) !== 1)
            begin tests_failed++; $display("FAIL basic_read_counts got rd2=%0d rd3=%0d exp=1 1", cnt_rd2 - rd2_0, cnt_rd3 - rd3_0); end
        tick();
        tests_run++;
        if ({in_ready, out_valid} !== 2'b10)
            begin tests_failed++; $display("FAIL basic_back_idle got rdy/v=%b exp=10", {in_ready, out_valid}); end
    endtask

    task automatic test_back_to_back();
        bit ok, irdy_bad;
        logic exp_y;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_a = i[1]; in_b = i[0]; in_valid = 1'b1;
            exp_y = i[1] | i[0];
            tests_run++;
            if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_ready_%0d got=%b exp=1", i, in_ready); end
            tick();
            in_valid = 1'b0;
            irdy_bad = 1'b0;
            ok = 1'b0;
            for (int c = 0; c < 20; c++) begin
                if (in_ready) irdy_bad = 1'b1;
                if (out_valid) begin ok = 1'b1; break; end
                tick();
            end
            tests_run++;
            if (ok !== 1'b1) begin tests_failed++; $display("FAIL b2b_timeout_%0d got out_valid=%b exp=1", i, out_valid); end
            tests_run++;
            if (irdy_bad !== 1'b0) begin tests_failed++; $display("FAIL b2b_in_ready_low_%0d got=%b exp=0", i, irdy_bad); end
            tests_run++;
            if ({out_y, out_err} !== {exp_y, 1'b0})
                begin tests_failed++; $display("FAIL b2b_result_%0d got y/err=%b exp=%b0", i, {out_y, out_err}, exp_y); end
            tick();
        end
    endtask

    task automatic test_write_stall();
        bit ok, stall_bad;
        int wr5_0;
        out_ready = 1'b1;
        in_a = 1'b0; in_b = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();                       // now in WR_B
        write_rdy = 1'b0;
        stall_bad = 1'b0;
        wr5_0 = cnt_wr5;
        for (int k = 0; k < 5; k++) begin
            #1;
            if (write_en || read_en || write_address != 3'd5) stall_bad = 1'b1;
            tick();
        end
        tests_run++;
        if (stall_bad !== 1'b0) begin tests_failed++; $display("FAIL stall_no_enable got=%b exp=0", stall_bad); end
        tests_run++;
        if (cnt_wr5 !== wr5_0) begin tests_failed++; $display("FAIL stall_no_write got=%0d exp=%0d", cnt_wr5, wr5_0); end
        write_rdy = 1'b1;
        #1;
        tests_run++;
        if ({write_en, write_address} !== {1'b1, 3'd5}) begin tests_failed++; $display("FAIL stall_release got en/addr=%b exp=1_101", {write_en, write_address}); end
        tick();
        tests_run++;
        if ((cnt_wr5 - wr5_0) !== 1 || read_address !== 3'd2)
            begin tests_failed++; $display("FAIL stall_one_write got writes=%0d raddr=%0d exp=1 2", cnt_wr5 - wr5_0, read_address); end
        wait_resp(20, ok);
        tests_run++;
        if ({ok, out_y, out_err} !== 3'b110) begin tests_failed++; $display("FAIL stall_resp got ok/y/err=%b exp=110", {ok, out_y, out_err}); end
        tick();
    endtask

    task automatic test_poll_timeout();
        bit ok;
        int rd2_0, rd3_0;
        out_ready = 1'b1;
        stub_stat0 = 1'b1;
        in_a = 1'b1; in_b = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();                       // now in POLL
        rd2_0 = cnt_rd2;
        rd3_0 = cnt_rd3;
        read_rdy = 1'b0;
        #1;
        tests_run++;
        if (read_en !== 1'b0) begin tests_failed++; $display("FAIL timeout_rdy_gate got=%b exp=0", read_en); end
        for (int k = 0; k < 3; k++) tick();
        read_rdy = 1'b1;
        wait_resp(30, ok);
        tests_run++;
        if (ok !== 1'b1) begin tests_failed++; $display("FAIL timeout_no_resp got=%b exp=1", ok); end
        tests_run++;
        if ((cnt_rd2 - rd2_0) !== 4) begin tests_failed++; $display("FAIL timeout_poll_count got=%0d exp=4", cnt_rd2 - rd2_0); end
        tests_run++;
        if ((cnt_rd3 - rd3_0) !== 0) begin tests_failed++; $display("FAIL timeout_no_data_read got=%0d exp=0", cnt_rd3 - rd3_0); end
        tests_run++;
        if ({out_y, out_err} !== 2'b01) begin tests_failed++; $display("FAIL timeout_resp got y/err=%b exp=01", {out_y, out_err}); end
        tick();
        stub_stat0 = 1'b0;
    endtask

    task automatic test_resp_hold();
        bit ok;
        out_ready = 1'b0;
        in_a = 1'b1; in_b = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_resp(20, ok);
        tests_run++;
        if (ok !== 1'b1) begin tests_failed++; $display("FAIL hold_no_resp got=%b exp=1", ok); end
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if ({out_valid, out_y, out_err, in_ready} !== 4'b1100)
                begin tests_failed++; $display("FAIL hold_stable_%0d got v/y/err/rdy=%b exp=1100", k, {out_valid, out_y, out_err, in_ready}); end
            tick();
        end
        out_ready = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL hold_same_cycle_ready got=%b exp=0", in_ready); end
        tick();
        tests_run++;
        if ({in_ready, out_valid} !== 2'b10) begin tests_failed++; $display("FAIL hold_ready_next got rdy/v=%b exp=10", {in_ready, out_valid}); end
    endtask

    task automatic test_reset_mid_poll();
        bit ok;
        out_ready = 1'b1;
        stub_stat0 = 1'b1;
        in_a = 1'b1; in_b = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();                       // one poll done, still in POLL
        tests_run++;
        if ({busy, read_address} !== {1'b1, 3'd2}) begin tests_failed++; $display("FAIL rstmid_in_poll got busy/raddr=%b exp=1_010", {busy, read_address}); end
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        #1;
        tests_run++;
        if ({busy, read_en, out_valid, in_ready} !== 4'b0001)
            begin tests_failed++; $display("FAIL rstmid_idle got busy/ren/v/rdy=%b exp=0001", {busy, read_en, out_valid, in_ready}); end
        tests_run++;
        if ({write_en, read_address} !== 4'd0) begin tests_failed++; $display("FAIL rstmid_bus got wen/raddr=%b exp=0", {write_en, read_address}); end
        stub_stat0 = 1'b0;
        in_a = 1'b0; in_b = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_resp(20, ok);
        tests_run++;
        if ({ok, out_y, out_err} !== 3'b110) begin tests_failed++; $display("FAIL rstmid_recover got ok/y/err=%b exp=110", {ok, out_y, out_err}); end
        tick();
    endtask

    task automatic test_exclusion();
        tests_run++;
        if (excl_viol !== 0) begin tests_failed++; $display("FAIL enable_exclusion got=%0d violations exp=0", excl_viol); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_write_stall();
        test_poll_timeout();
        test_resp_hold();
        test_reset_mid_poll();
        test_exclusion();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
